// File: rtl/burst_responder_if.sv
// Burst interconnect bundle between initiator (master) and responder (slave):
// request, write-data, read-data and response valid/ready channels.
interface burst_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = 4
);
    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_wr;
    logic [ADDR_W-1:0] io_req_address;
    logic [LEN_W-1:0]  io_req_length;
    logic              io_wdata_valid;
    logic [DATA_W-1:0] io_wdata;
    logic              io_wdata_ready;
    logic              io_rdata_valid;
    logic [DATA_W-1:0] io_rdata;
    logic              io_rdata_last;
    logic              io_rdata_ready;
    logic              io_resp_valid;
    logic              io_resp_err;
    logic              io_resp_ready;

    modport master (
        output io_req_valid, io_req_wr, io_req_address, io_req_length,
        output io_wdata_valid, io_wdata, io_rdata_ready, io_resp_ready,
        input  io_req_ready, io_wdata_ready, io_rdata_valid, io_rdata, io_rdata_last,
        input  io_resp_valid, io_resp_err
    );

    modport slave (
        input  io_req_valid, io_req_wr, io_req_address, io_req_length,
        input  io_wdata_valid, io_wdata, io_rdata_ready, io_resp_ready,
        output io_req_ready, io_wdata_ready, io_rdata_valid, io_rdata, io_rdata_last,
        output io_resp_valid, io_resp_err
    );
endinterface

// File: rtl/burst_responder.sv
// Burst responder serving single/multi-beat reads and writes from a local register array.
// Define BURST_RESPONDER_ERR_EN to flag zero-length and wrapping bursts with an error response.
module burst_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = 4
) (
    input logic                clock,
    input logic                reset,
    burst_responder_if.slave   bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_err;
    logic [DATA_W-1:0] mem_q [Depth];

    logic              req_ready, wdata_ready, rdata_valid, rdata_last, resp_valid, resp_err;
    logic [DATA_W-1:0] rdata;

`ifdef BURST_RESPONDER_ERR_EN
    localparam int unsigned SumW = ADDR_W + LEN_W + 1;
    logic [SumW-1:0] req_end;

    always_comb begin
        req_end = SumW'(bus.io_req_address) + SumW'(bus.io_req_length);
        req_err = (bus.io_req_length == '0) || (req_end > SumW'(Depth));
    end
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset: contents survive reset by design.
    always_ff @(posedge clock) begin
        if (state_q == StWrite && bus.io_wdata_valid && !err_q) begin
            mem_q[ptr_q] <= bus.io_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        rdata       = '0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (bus.io_req_valid) begin
                    ptr_d = bus.io_req_address;
                    cnt_d = bus.io_req_length;
                    err_d = req_err;
                    if (bus.io_req_length == '0) begin
                        state_d = StResp;
                    end else if (bus.io_req_wr) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                wdata_ready = 1'b1;
                if (bus.io_wdata_valid) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StResp;
                    end
                end
            end
            StRead: begin
                rdata_valid = 1'b1;
                rdata       = err_q ? '0 : mem_q[ptr_q];
                rdata_last  = (cnt_q == LEN_W'(1));
                if (bus.io_rdata_ready) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (bus.io_resp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    assign bus.io_req_ready   = req_ready;
    assign bus.io_wdata_ready = wdata_ready;
    assign bus.io_rdata_valid = rdata_valid;
    assign bus.io_rdata       = rdata;
    assign bus.io_rdata_last  = rdata_last;
    assign bus.io_resp_valid  = resp_valid;
    assign bus.io_resp_err    = resp_err;
endmodule

// File: tb/tb_burst_responder.sv
// Bench for burst_responder: directed steps plus random bursts checked against an array model.
// Expected error responses follow BURST_RESPONDER_ERR_EN when it is defined for the build.
module tb_burst_responder;
    logic clk;
    logic rst;

    burst_responder_if #(.DATA_W(32), .ADDR_W(4), .LEN_W(4)) bus ();

    burst_responder #(.DATA_W(32), .ADDR_W(4), .LEN_W(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_m [16];
    logic [31:0] wd [16];
    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic excl();
        chk("excl", 32'($countones({bus.io_req_ready, bus.io_wdata_ready,
                                    bus.io_rdata_valid, bus.io_resp_valid}) <= 1), 32'd1);
    endtask

    function automatic logic exp_err(input logic [3:0] addr, input logic [3:0] len);
`ifdef BURST_RESPONDER_ERR_EN
        return (len == 4'd0) || (int'(addr) + int'(len) > 16);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int stall_n(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic request(input logic wr, input logic [3:0] addr, input logic [3:0] len);
        int n;
        n = 0;
        bus.io_req_valid   = 1'b1;
        bus.io_req_wr      = wr;
        bus.io_req_address = addr;
        bus.io_req_length  = len;
        while (!bus.io_req_ready && n < 50) begin
            step();
            n++;
        end
        chk("req_ready", 32'(bus.io_req_ready), 32'd1);
        step();
        bus.io_req_valid   = 1'b0;
        bus.io_req_address = 4'($urandom);
        bus.io_req_length  = 4'($urandom);
    endtask

    task automatic finish_resp(input logic err, input int stall);
        chk("resp_valid", 32'(bus.io_resp_valid), 32'd1);
        chk("resp_err", 32'(bus.io_resp_err), 32'(err));
        excl();
        for (int i = 0; i < stall; i++) begin
            step();
            chk("resp_hold_valid", 32'(bus.io_resp_valid), 32'd1);
            chk("resp_hold_err", 32'(bus.io_resp_err), 32'(err));
            chk("req_ready_busy", 32'(bus.io_req_ready), 32'd0);
        end
        bus.io_resp_ready = 1'b1;
        step();
        bus.io_resp_ready = 1'b0;
        chk("resp_done", 32'(bus.io_resp_valid), 32'd0);
        chk("req_ready_back", 32'(bus.io_req_ready), 32'd1);
    endtask

    task automatic write_burst(input logic [3:0] addr, input logic [3:0] len,
                               input int mode, input int rstall);
        logic err;
        logic [3:0] a;
        err = exp_err(addr, len);
        request(1'b1, addr, len);
        if (len == 4'd0) begin
            chk("wr0_no_wready", 32'(bus.io_wdata_ready), 32'd0);
            finish_resp(err, rstall);
            return;
        end
        chk("wready_first", 32'(bus.io_wdata_ready), 32'd1);
        for (int i = 0; i < int'(len); i++) begin
            bus.io_wdata_valid = 1'b0;
            for (int s = stall_n(mode); s > 0; s--) begin
                chk("wready_stall", 32'(bus.io_wdata_ready), 32'd1);
                excl();
                step();
            end
            bus.io_wdata_valid = 1'b1;
            bus.io_wdata       = wd[i];
            step();
            bus.io_wdata_valid = 1'b0;
            a = addr + 4'(i);
            if (!err) mem_m[a] = wd[i];
        end
        chk("wready_done", 32'(bus.io_wdata_ready), 32'd0);
        finish_resp(err, rstall);
    endtask

    task automatic read_burst(input logic [3:0] addr, input logic [3:0] len,
                              input int mode, input int rstall);
        logic err;
        logic [3:0] a;
        logic [31:0] expd;
        err = exp_err(addr, len);
        request(1'b0, addr, len);
        if (len == 4'd0) begin
            chk("rd0_no_rvalid", 32'(bus.io_rdata_valid), 32'd0);
            finish_resp(err, rstall);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            a    = addr + 4'(i);
            expd = err ? 32'd0 : mem_m[a];
            bus.io_rdata_ready = 1'b0;
            for (int s = stall_n(mode); s > 0; s--) begin
                chk("rvalid_stall", 32'(bus.io_rdata_valid), 32'd1);
                chk("rdata_stall", bus.io_rdata, expd);
                excl();
                step();
            end
            chk("rvalid", 32'(bus.io_rdata_valid), 32'd1);
            chk("rdata", bus.io_rdata, expd);
            chk("rlast", 32'(bus.io_rdata_last), 32'(i == int'(len) - 1));
            bus.io_rdata_ready = 1'b1;
            step();
            bus.io_rdata_ready = 1'b0;
        end
        chk("rvalid_done", 32'(bus.io_rdata_valid), 32'd0);
        finish_resp(err, rstall);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rl;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.io_req_valid = 1'b0;
        bus.io_req_wr = 1'b0;
        bus.io_req_address = '0;
        bus.io_req_length = '0;
        bus.io_wdata_valid = 1'b0;
        bus.io_wdata = '0;
        bus.io_rdata_ready = 1'b0;
        bus.io_resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.io_req_ready), 32'd1);
        chk("rst_wready", 32'(bus.io_wdata_ready), 32'd0);
        chk("rst_rvalid", 32'(bus.io_rdata_valid), 32'd0);
        chk("rst_resp_valid", 32'(bus.io_resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.io_resp_err), 32'd0);
        chk("rst_rlast", 32'(bus.io_rdata_last), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Preload the whole array so every later read has a known expectation.
        for (int i = 0; i < 16; i++) wd[i] = $urandom;
        write_burst(4'h0, 4'd8, 0, 0);
        for (int i = 0; i < 8; i++) wd[i] = wd[i + 8];
        write_burst(4'h8, 4'd8, 2, 1);

        wd[0] = 32'hA;
        write_burst(4'h7, 4'd1, 0, 0);
        read_burst(4'h7, 4'd1, 0, 0);
        chk("single_model", mem_m[7], 32'hA);

        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        write_burst(4'h2, 4'd4, 0, 0);
        read_burst(4'h2, 4'd4, 1, 0);

        for (int i = 0; i < 4; i++) wd[i] = 32'h11 * 32'(i + 1);
        write_burst(4'hE, 4'd4, 1, 0);
        read_burst(4'hE, 4'd2, 0, 0);
        read_burst(4'h0, 4'd2, 0, 0);
        read_burst(4'hE, 4'd4, 0, 1);

        read_burst(4'h3, 4'd0, 0, 0);
        write_burst(4'h9, 4'd0, 0, 2);

        // Reset in the middle of a read burst, with a request held during reset.
        request(1'b0, 4'h2, 4'd4);
        for (int i = 0; i < 2; i++) begin
            ra = 4'h2 + 4'(i);
            chk("mid_rdata", bus.io_rdata, mem_m[ra]);
            bus.io_rdata_ready = 1'b1;
            step();
        end
        #2;
        rst = 1'b1;
        bus.io_req_valid = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(bus.io_rdata_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.io_req_ready), 32'd1);
        bus.io_rdata_ready = 1'b0;
        step();
        step();
        bus.io_req_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_req_ready", 32'(bus.io_req_ready), 32'd1);
        chk("post_rst_rvalid", 32'(bus.io_rdata_valid), 32'd0);
        read_burst(4'h0, 4'd8, 2, 0);

        // Response stall, then a request queued during the resp handshake.
        wd[0] = $urandom;
        request(1'b1, 4'h5, 4'd1);
        bus.io_wdata_valid = 1'b1;
        bus.io_wdata = wd[0];
        step();
        bus.io_wdata_valid = 1'b0;
        mem_m[5] = wd[0];
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", 32'(bus.io_resp_valid), 32'd1);
            chk("stall_resp_err", 32'(bus.io_resp_err), 32'd0);
            chk("stall_req_ready", 32'(bus.io_req_ready), 32'd0);
            step();
        end
        bus.io_req_valid = 1'b1;
        bus.io_req_wr = 1'b0;
        bus.io_req_address = 4'h5;
        bus.io_req_length = 4'd1;
        bus.io_resp_ready = 1'b1;
        step();
        bus.io_resp_ready = 1'b0;
        chk("b2b_idle", 32'(bus.io_req_ready), 32'd1);
        chk("b2b_not_yet", 32'(bus.io_rdata_valid), 32'd0);
        step();
        bus.io_req_valid = 1'b0;
        chk("b2b_rvalid", 32'(bus.io_rdata_valid), 32'd1);
        chk("b2b_rdata", bus.io_rdata, mem_m[5]);
        chk("b2b_rlast", 32'(bus.io_rdata_last), 32'd1);
        bus.io_rdata_ready = 1'b1;
        step();
        bus.io_rdata_ready = 1'b0;
        finish_resp(1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            ra = 4'($urandom);
            rl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
            for (int i = 0; i < 16; i++) wd[i] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                write_burst(ra, rl, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            end else begin
                read_burst(ra, rl, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
